prog_loader: RTL
================

Name: prog_loader

Overview:
- Receive side of the serial program-load link.
- Consumes the 1-bit mosi stream and 2-bit mode lines from the FPGA-demo driver.
- Deserialises 13-bit frames and writes each payload byte into the core's instruction memory (imem) or data/register memory (dmem).
- Issues a start pulse to the tiny processor core, then reports completion back to the driver through done_out.

Parameters:
- FRAME_BITS, 13: bits per serial frame, LSB first: bits[3:0] = address, bits[11:4] = data, bit[12] = pad (always 0).
- ADDR_W, 4: memory address width (16 entries).
- DATA_W, 8: memory data width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- mosi_in  in  1  serial data from driver.
- mode_in  in  2  link mode: 00 idle, 01 load imem, 10 load dmem, 11 run.
- halt_in  in  1  core has executed its halt/last instruction; level.
- imem_we  out  1  imem write strobe, one cycle.
- dmem_we  out  1  dmem write strobe, one cycle.
- mem_waddr  out  ADDR_W  write address, shared by both memories.
- mem_wdata  out  DATA_W  write data, shared by both memories.
- core_start  out  1  one-cycle pulse on entering RUN.
- core_run  out  1  high while the core owns the memories.
- done_out  out  1  run complete, to driver done_in.
- frame_err  out  1  sticky: short or aborted frame seen; cleared only by rst.
- frames_ok  out  5  count of committed frames, saturates at 31.

Behaviour:
- Reset values: all outputs 0; state IDLE; shift register 0; bit count 0.
- Sampling: mosi_in is sampled on posedge while state is SHIFT_I or SHIFT_D.
- Shift register: 13 bits, right-shift, new bit enters at bit[12].
  - The last 13 samples before mode leaves 01/10 form the frame.
  - Extra leading samples (driver preamble cycles) are discarded automatically.
- bit_cnt counts samples and saturates at FRAME_BITS.
- State IDLE:
  - mode 01 -> SHIFT_I; mode 10 -> SHIFT_D. In both cases the current cycle's mosi is sampled and bit_cnt = 1.
  - mode 11 -> RUN.
  - mode 00 -> stay.
- States SHIFT_I / SHIFT_D:
  - mode unchanged -> keep sampling.
  - mode 00 -> COMMIT.
  - Any other mode is an abort: frame_err=1, no write, next state follows the IDLE rules applied to the new mode.
- State COMMIT (one cycle):
  - If bit_cnt == 13: pulse imem_we or dmem_we (according to the origin state), with mem_waddr = sr[3:0] and mem_wdata = sr[11:4]; increment frames_ok.
  - Otherwise: frame_err=1 and no write.
  - sr[12] == 1 also sets frame_err, but the write still occurs.
  - Clears bit_cnt, then goes to IDLE. Mode is re-evaluated from IDLE on the next cycle.
- Write latency: strobe appears exactly 1 cycle after the first mode==00 sample.
- State RUN:
  - core_start=1 for the first cycle only; core_run=1 throughout.
  - halt_in=1 -> HALTED.
  - mode 00 -> IDLE (driver abort); core_run drops next cycle.
- State HALTED:
  - done_out=1, core_run=1.
  - mode 00 -> IDLE, and done_out drops the same cycle the state changes.
  - mode 01/10 in HALTED -> IDLE with frame_err=1.
- Writes never occur in RUN or HALTED.
- mem_waddr/mem_wdata hold their last value when no strobe is active.
- Simultaneous events:
  - halt_in and mode 00 in the same RUN cycle -> IDLE (the abort wins).
  - rst mid-frame discards the partial frame with no write.
  - frames_ok is not cleared by a new load session; only rst clears it.

Decomposition:
- Package prog_loader_pkg holds:
  - link_mode_t enum {LM_IDLE=2'b00, LM_IMEM=2'b01, LM_DMEM=2'b10, LM_RUN=2'b11}, shared with the driver;
  - loader_state_t {IDLE, SHIFT_I, SHIFT_D, COMMIT, RUN, HALTED};
  - the FRAME_BITS / ADDR_W / DATA_W constants.
- One sub-module, frame_deser: shift register plus saturating bit counter, with ports shift_en, clr, sr, full. The FSM stays in prog_loader.

Test Plan:
- Single imem frame: mode 01 for 2 preamble cycles + 13 bits of {0, 8'hA5, 4'h3}, then mode 00 -> imem_we pulses 1 cycle later with waddr=3, wdata=A5; frames_ok=1; frame_err=0.
- Full load: 16 imem frames then 16 dmem frames with addr i / data i^8'h5A -> 16 imem_we and 16 dmem_we strobes with matching addr/data; frames_ok=31 (saturated).
- Short frame: mode 10 for 9 cycles then 00 -> no dmem_we; frame_err=1 and stays 1 through later good frames.
- Abort: mode 01 for 6 cycles, then 10 directly -> frame_err=1, no imem write; the following 13-bit dmem frame commits normally.
- Run handshake: mode 11 -> core_start high for exactly 1 cycle, core_run=1; halt_in=1 after 20 cycles -> done_out=1 the next cycle; mode 00 -> done_out=0 and core_run=0.
- Reset mid-frame: rst asserted at bit 7 of an imem frame -> no write; all outputs 0 the next cycle; a subsequent full frame commits correctly.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program-load link.
// Used by the loader FSM, its deserialiser and the driver side.
package prog_loader_pkg;

  localparam int FRAME_BITS = 13;
  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 8;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int FOK_W      = 5;

  typedef enum logic [1:0] {
    LM_IDLE = 2'b00,
    LM_IMEM = 2'b01,
    LM_DMEM = 2'b10,
    LM_RUN  = 2'b11
  } link_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_I,
    SHIFT_D,
    COMMIT,
    RUN,
    HALTED
  } loader_state_t;

  // Where the FSM goes when a mode is seen from IDLE (or after an abort)
  function automatic loader_state_t mode_state(link_mode_t m);
    loader_state_t s;
    unique case (m)
      LM_IMEM: s = SHIFT_I;
      LM_DMEM: s = SHIFT_D;
      LM_RUN:  s = RUN;
      default: s = IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/frame_deser.sv
// Frame deserialiser: right-shifting frame register with a
// saturating sample counter; full means a whole frame is held.
module frame_deser
  import prog_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din,
  input  logic                  shift_en,
  input  logic                  clr,
  output logic [FRAME_BITS-1:0] sr,
  output logic                  full
);

  logic [FRAME_BITS-1:0] sr_q;
  logic [CNT_W-1:0]      cnt_q;

  assign sr   = sr_q;
  assign full = (cnt_q == CNT_W'(FRAME_BITS));

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (shift_en)
        sr_q <= {din, sr_q[FRAME_BITS-1:1]};
      // clr with shift_en restarts a frame on this sample
      if (clr)
        cnt_q <= shift_en ? CNT_W'(1) : '0;
      else if (shift_en && !full)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Receive side of the serial program-load link: frames into
// imem/dmem writes, then the core start/run/done handshake.
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mosi_in,
  input  logic [1:0]        mode_in,
  input  logic              halt_in,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_start,
  output logic              core_run,
  output logic              done_out,
  output logic              frame_err,
  output logic [FOK_W-1:0]  frames_ok
);

  loader_state_t     state_q;
  logic              imem_we_q;
  logic              dmem_we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              start_q;
  logic              run_q;
  logic              done_q;
  logic              err_q;
  logic [FOK_W-1:0]  fok_q;

  link_mode_t            mode;
  link_mode_t            origin;
  logic                  is_load;
  logic                  shift_en;
  logic                  clr;
  logic [FRAME_BITS-1:0] sr;
  logic                  full;

  assign mode    = link_mode_t'(mode_in);
  assign is_load = (mode == LM_IMEM) || (mode == LM_DMEM);
  assign origin  = (state_q == SHIFT_I) ? LM_IMEM : LM_DMEM;

  always_comb begin
    shift_en = 1'b0;
    clr      = 1'b0;
    unique case (state_q)
      IDLE: begin
        shift_en = is_load;
        clr      = is_load;
      end
      SHIFT_I, SHIFT_D: begin
        if (mode == origin) begin
          shift_en = 1'b1;
        end else if (mode != LM_IDLE) begin
          shift_en = is_load;
          clr      = 1'b1;
        end
      end
      COMMIT:  clr = 1'b1;
      default: ;
    endcase
  end

  frame_deser u_deser (
    .clk      (clk),
    .rst      (rst),
    .din      (mosi_in),
    .shift_en (shift_en),
    .clr      (clr),
    .sr       (sr),
    .full     (full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      imem_we_q <= 1'b0;
      dmem_we_q <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      start_q   <= 1'b0;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      fok_q     <= '0;
    end else begin
      imem_we_q <= 1'b0;
      dmem_we_q <= 1'b0;
      start_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          state_q <= mode_state(mode);
          if (mode == LM_RUN) begin
            start_q <= 1'b1;
            run_q   <= 1'b1;
          end
        end
        SHIFT_I, SHIFT_D: begin
          if (mode == LM_IDLE) begin
            state_q <= COMMIT;
            if (full) begin
              imem_we_q <= (state_q == SHIFT_I);
              dmem_we_q <= (state_q == SHIFT_D);
              waddr_q   <= sr[ADDR_W-1:0];
              wdata_q   <= sr[ADDR_W+DATA_W-1:ADDR_W];
              if (fok_q != '1)
                fok_q <= fok_q + FOK_W'(1);
            end else begin
              err_q <= 1'b1;
            end
            if (sr[FRAME_BITS-1])
              err_q <= 1'b1;
          end else if (mode != origin) begin
            // mode jumped without passing through idle: drop the frame
            err_q   <= 1'b1;
            state_q <= mode_state(mode);
            if (mode == LM_RUN) begin
              start_q <= 1'b1;
              run_q   <= 1'b1;
            end
          end
        end
        COMMIT: state_q <= IDLE;
        RUN: begin
          if (mode == LM_IDLE) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
          end else if (halt_in) begin
            state_q <= HALTED;
            done_q  <= 1'b1;
          end
        end
        HALTED: begin
          if (mode != LM_RUN) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            if (mode != LM_IDLE)
              err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_we    = imem_we_q;
  assign dmem_we    = dmem_we_q;
  assign mem_waddr  = waddr_q;
  assign mem_wdata  = wdata_q;
  assign core_start = start_q;
  assign core_run   = run_q;
  assign done_out   = done_q;
  assign frame_err  = err_q;
  assign frames_ok  = fok_q;

endmodule
